// File: rtl/conv_mac_engine_if.sv
// Operand/result memory and control bundle for conv_mac_engine.
// master = engine side, slave = wrapper/memory side.
interface conv_mac_engine_if #(
    parameter int DATA_W = 8,
    parameter int AW_X   = 5,
    parameter int AW_Y   = 3,
    parameter int AW_Z   = 6,
    parameter int Z_W    = 32
);
    logic              start;
    logic [AW_X:0]     size_x;
    logic [AW_Y:0]     size_y;
    logic [AW_X-1:0]   x_addr;
    logic [DATA_W-1:0] x_data;
    logic [AW_Y-1:0]   y_addr;
    logic [DATA_W-1:0] y_data;
    logic [AW_Z-1:0]   z_addr;
    logic [Z_W-1:0]    z_data;
    logic              z_we;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  start, size_x, size_y, x_data, y_data,
        output x_addr, y_addr, z_addr, z_data, z_we, busy, done, err
    );

    modport slave (
        output start, size_x, size_y, x_data, y_data,
        input  x_addr, y_addr, z_addr, z_data, z_we, busy, done, err
    );
endinterface

// File: rtl/conv_mac_engine.sv
// Full linear convolution Z[i] = sum X[j]*Y[i-j] over 1-cycle-latency operand memories.
// Define CONV_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
module conv_mac_engine #(
    parameter int DATA_W = 8,
    parameter int AW_X   = 5,
    parameter int AW_Y   = 3,
    parameter int AW_Z   = 6,
    parameter int Z_W    = 32
) (
    input logic               clk,
    input logic               rst_a,
    conv_mac_engine_if.master bus
);
    localparam int CW = AW_Z + 2;
    localparam int XW = AW_X + 1;
    localparam int YW = AW_Y + 1;
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [2:0] {IDLE, CALC, LAST, WRITE, FINISH} state_t;
    state_t state, stateNext;

    logic [AW_X:0]     sizeX;
    logic [AW_Y:0]     sizeY;
    logic [AW_Z-1:0]   iIdx;
    logic [AW_X-1:0]   jIdx;
    logic [AW_X-1:0]   xAddr;
    logic [AW_Y-1:0]   yAddr;
    logic [Z_W-1:0]    acc;
    logic [Z_W-1:0]    prodExt;
    logic              validD;
    logic              errReg;
    logic              sizeBad;
    logic              jAtHi;
    logic              iLast;
    logic [CW-1:0]     iExt, iNextExt, nxExt, nyExt, jHi, jLoNext, lastIdx;

    function automatic logic [CW-1:0] jLoOf(input logic [CW-1:0] i, input logic [CW-1:0] ny);
        return (i + ONE >= ny) ? i + ONE - ny : '0;
    endfunction

    assign sizeBad = (bus.size_x == '0) || (bus.size_x > XW'(2 ** AW_X)) ||
                     (bus.size_y == '0) || (bus.size_y > YW'(2 ** AW_Y));

    assign iExt     = CW'(iIdx);
    assign iNextExt = iExt + ONE;
    assign nxExt    = CW'(sizeX);
    assign nyExt    = CW'(sizeY);
    assign jHi      = (iExt < nxExt - ONE) ? iExt : nxExt - ONE;
    assign jAtHi    = (CW'(jIdx) == jHi);
    assign lastIdx  = nxExt + nyExt - ONE - ONE;
    assign iLast    = (iExt == lastIdx);
    assign jLoNext  = jLoOf(iNextExt, nyExt);

`ifdef CONV_SIGNED_EN
    logic signed [2*DATA_W-1:0] prodS;
    assign prodS   = $signed(bus.x_data) * $signed(bus.y_data);
    assign prodExt = {{(Z_W-2*DATA_W){prodS[2*DATA_W-1]}}, prodS};
`else
    logic [2*DATA_W-1:0] prodU;
    assign prodU   = bus.x_data * bus.y_data;
    assign prodExt = {{(Z_W-2*DATA_W){1'b0}}, prodU};
`endif

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (bus.start) stateNext = sizeBad ? FINISH : CALC;
            CALC:    if (jAtHi) stateNext = LAST;
            LAST:    stateNext = WRITE;
            WRITE:   stateNext = iLast ? FINISH : CALC;
            FINISH:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Read data returns one cycle after each CALC address, so validD marks
    // the cycle in which x_data/y_data belong to an issued term.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            sizeX  <= '0;
            sizeY  <= '0;
            iIdx   <= '0;
            jIdx   <= '0;
            xAddr  <= '0;
            yAddr  <= '0;
            acc    <= '0;
            validD <= 1'b0;
            errReg <= 1'b0;
        end else begin
            validD <= (state == CALC);
            if (validD) acc <= acc + prodExt;
            unique case (state)
                IDLE: if (bus.start) begin
                    sizeX  <= bus.size_x;
                    sizeY  <= bus.size_y;
                    acc    <= '0;
                    errReg <= sizeBad;
                    if (!sizeBad) begin
                        iIdx  <= '0;
                        jIdx  <= '0;
                        xAddr <= '0;
                        yAddr <= '0;
                    end
                end
                CALC: if (!jAtHi) begin
                    jIdx  <= jIdx + AW_X'(1);
                    xAddr <= jIdx + AW_X'(1);
                    yAddr <= AW_Y'(iExt - CW'(jIdx) - ONE);
                end
                WRITE: begin
                    acc  <= '0;
                    iIdx <= iIdx + AW_Z'(1);
                    if (!iLast) begin
                        jIdx  <= AW_X'(jLoNext);
                        xAddr <= AW_X'(jLoNext);
                        yAddr <= AW_Y'(iNextExt - jLoNext);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.x_addr = xAddr;
    assign bus.y_addr = yAddr;
    assign bus.z_addr = iIdx;
    assign bus.z_data = acc;
    assign bus.z_we   = (state == WRITE);
    assign bus.busy   = state inside {CALC, LAST, WRITE};
    assign bus.done   = (state == FINISH);
    assign bus.err    = errReg;
endmodule

// File: tb/tb_conv_mac_engine.sv
// Randomized self-checking bench for conv_mac_engine against a direct
// double-loop convolution model with per-output term counts for latency.
module tb_conv_mac_engine;
    localparam int DATA_W = 8;
    localparam int AW_X   = 5;
    localparam int AW_Y   = 3;
    localparam int AW_Z   = 6;
    localparam int Z_W    = 32;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;

    conv_mac_engine_if #(.DATA_W(DATA_W), .AW_X(AW_X), .AW_Y(AW_Y), .AW_Z(AW_Z), .Z_W(Z_W)) bus ();

    conv_mac_engine #(.DATA_W(DATA_W), .AW_X(AW_X), .AW_Y(AW_Y), .AW_Z(AW_Z), .Z_W(Z_W)) dut (
        .clk  (clk),
        .rst_a(rst_a),
        .bus  (bus)
    );

    int unsigned checks    = 0;
    int unsigned failures  = 0;
    int unsigned cyc       = 0;
    int unsigned doneCount = 0;

    logic [DATA_W-1:0] xMem [32];
    logic [DATA_W-1:0] yMem [8];
    logic [AW_Z-1:0]   wAddr[$];
    logic [Z_W-1:0]    wData[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        bus.x_data <= xMem[bus.x_addr];
        bus.y_data <= yMem[bus.y_addr];
    end

    always @(negedge clk) begin
        if (bus.z_we) begin
            wAddr.push_back(bus.z_addr);
            wData.push_back(bus.z_data);
        end
        if (bus.done) doneCount++;
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [Z_W-1:0] refProd(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef CONV_SIGNED_EN
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        return Z_W'(sa * sb);
`else
        int unsigned ua, ub;
        ua = a;
        ub = b;
        return Z_W'(ua * ub);
`endif
    endfunction

    task automatic fillRandom();
        for (int k = 0; k < 32; k++) xMem[k] = DATA_W'($urandom);
        for (int k = 0; k < 8; k++)  yMem[k] = DATA_W'($urandom);
    endtask

    task automatic runConv(input int unsigned nx, input int unsigned ny, input bit midStart);
        logic [Z_W-1:0]  zRef[64];
        int unsigned     nTerm[64];
        int unsigned     nOut, expLat, t0, doneCyc;
        bit              expErr, seen, busyDrop;
        logic [AW_X-1:0] xa0;
        logic [AW_Y-1:0] ya0;

        expErr = (nx < 1) || (nx > 32) || (ny < 1) || (ny > 8);
        for (int k = 0; k < 64; k++) begin
            zRef[k]  = '0;
            nTerm[k] = 0;
        end
        nOut = 0;
        if (!expErr) begin
            for (int j = 0; j < int'(nx); j++)
                for (int k = 0; k < int'(ny); k++) begin
                    zRef[j+k] = zRef[j+k] + refProd(xMem[j], yMem[k]);
                    nTerm[j+k]++;
                end
            nOut = nx + ny - 1;
        end
        expLat = 0;
        for (int k = 0; k < int'(nOut); k++) expLat += nTerm[k] + 2;

        @(negedge clk);
        wAddr.delete();
        wData.delete();
        doneCount  = 0;
        xa0        = bus.x_addr;
        ya0        = bus.y_addr;
        bus.size_x = (AW_X+1)'(nx);
        bus.size_y = (AW_Y+1)'(ny);
        bus.start  = 1'b1;
        @(negedge clk);
        t0        = cyc;
        bus.start = 1'b0;
        seen      = 1'b0;
        busyDrop  = 1'b0;
        doneCyc   = 0;
        for (int c = 0; c < 1000; c++) begin
            if (bus.done) begin
                seen    = 1'b1;
                doneCyc = cyc;
                break;
            end
            if (!bus.busy) busyDrop = 1'b1;
            bus.start = midStart && (c == 2);
            @(negedge clk);
        end
        bus.start = 1'b0;

        checkVal("doneSeen", seen, 1);
        if (seen) checkVal("doneLatency", doneCyc - t0, expLat);
        checkVal("errAtDone", bus.err, expErr);
        repeat (3) @(negedge clk);
        #1;
        checkVal("doneCount", doneCount, 1);
        checkVal("errSticky", bus.err, expErr);
        checkVal("zWrites", wAddr.size(), nOut);
        for (int k = 0; k < wAddr.size() && k < int'(nOut); k++) begin
            checkVal($sformatf("zAddr[%0d]", k), wAddr[k], k);
            checkVal($sformatf("zData[%0d]", k), wData[k], zRef[k]);
        end
        if (expErr) begin
            checkVal("xAddrHeld", bus.x_addr, xa0);
            checkVal("yAddrHeld", bus.y_addr, ya0);
        end else begin
            checkVal("busyHeld", busyDrop, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned weSeen;
        bus.start  = 1'b0;
        bus.size_x = '0;
        bus.size_y = '0;
        fillRandom();

        repeat (2) @(negedge clk);
        checkVal("rstXAddr", bus.x_addr, 0);
        checkVal("rstYAddr", bus.y_addr, 0);
        checkVal("rstZAddr", bus.z_addr, 0);
        checkVal("rstZData", bus.z_data, 0);
        checkVal("rstZWe", bus.z_we, 0);
        checkVal("rstBusy", bus.busy, 0);
        checkVal("rstDone", bus.done, 0);
        checkVal("rstErr", bus.err, 0);
        rst_a = 1'b0;

        // basic example
        xMem[0] = 8'd1; xMem[1] = 8'd2; xMem[2] = 8'd3;
        yMem[0] = 8'd1; yMem[1] = 8'd1;
        runConv(3, 2, 1'b0);
        if (wData.size() == 4) begin
            checkVal("basicZ1", wData[1], 3);
            checkVal("basicZ2", wData[2], 5);
        end

        // maximum sizes, all ones
        for (int k = 0; k < 32; k++) xMem[k] = 8'hFF;
        for (int k = 0; k < 8; k++)  yMem[k] = 8'hFF;
        runConv(32, 8, 1'b0);
`ifndef CONV_SIGNED_EN
        if (wData.size() == 39) begin
            checkVal("maxZ0", wData[0], 65025);
            checkVal("maxZ7", wData[7], 520200);
            checkVal("maxZ31", wData[31], 520200);
        end
`endif

        // size errors, then a valid start clears err
        runConv(0, 3, 1'b0);
        runConv(5, 9, 1'b0);
        fillRandom();
        runConv(4, 3, 1'b0);

        // start pulsed while busy
        fillRandom();
        runConv(12, 5, 1'b1);

        // reset after the second write
        fillRandom();
        @(negedge clk);
        wAddr.delete();
        wData.delete();
        doneCount  = 0;
        bus.size_x = 6'd10;
        bus.size_y = 4'd4;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        weSeen    = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (bus.z_we) weSeen++;
            if (weSeen == 2) break;
        end
        checkVal("rstMidWe2", weSeen, 2);
        rst_a = 1'b1;
        #1;
        checkVal("rstMidXAddr", bus.x_addr, 0);
        checkVal("rstMidYAddr", bus.y_addr, 0);
        checkVal("rstMidZAddr", bus.z_addr, 0);
        checkVal("rstMidZData", bus.z_data, 0);
        checkVal("rstMidZWe", bus.z_we, 0);
        checkVal("rstMidBusy", bus.busy, 0);
        checkVal("rstMidDone", bus.done, 0);
        repeat (3) @(negedge clk);
        #1;
        checkVal("rstMidNoDone", doneCount, 0);
        checkVal("rstMidWrites", wAddr.size(), 2);
        @(negedge clk);
        rst_a = 1'b0;
        runConv(10, 4, 1'b0);

        // sign handling
        xMem[0] = 8'hFF; xMem[1] = 8'h02;
        yMem[0] = 8'h03;
        runConv(2, 1, 1'b0);
        if (wData.size() == 2) begin
`ifdef CONV_SIGNED_EN
            checkVal("signZ0", wData[0], 32'hFFFF_FFFD);
`else
            checkVal("signZ0", wData[0], 765);
`endif
            checkVal("signZ1", wData[1], 6);
        end

        // randomized sizes, with single-sample boundaries first
        for (int r = 0; r < 12; r++) begin
            int unsigned nx, ny;
            nx = (r == 0) ? 1 : $urandom_range(1, 32);
            ny = (r == 1) ? 1 : $urandom_range(1, 8);
            fillRandom();
            runConv(nx, ny, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
